mpu_matrix_loader: RTL and testbench

Assembles the packed 5x5 int8 operand bus that the MPU determinant and other matrix operations consume.
Accepts signed 8-bit elements one at a time over a valid/ready stream, in row-major order, for an N x N matrix with N = 1..5.
Unused positions are zero-filled. Signals completion with a one-cycle done pulse while holding the matrix stable for downstream operations.

---
 rtl/mpu_matrix_loader.sv | 123 ++++++++++++
 tb/tb_mpu_matrix_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_matrix_loader.sv
// Streams up to 25 signed int8 elements row-major into a zero-filled packed 5x5 operand bus.
// Optional MPU_LOADER_TRANSPOSE_EN: stream index (row,col) lands at bus position (col,row).
module mpu_matrix_loader #(
   parameter int DIM   = 5,
   parameter int WIDTH = 8
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              start,
   input  logic signed [7:0]                 size,
   input  logic signed [WIDTH-1:0]           in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic signed [0:DIM*DIM*WIDTH-1]   matrix,
   output logic signed [7:0]                 size_out,
   output logic [4:0]                        count,
   output logic                              busy,
   output logic                              done,
   output logic                              error
);

   localparam int NEL = DIM * DIM;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]                       state_q, state_d;
   logic signed [0:DIM*DIM*WIDTH-1]  matrix_q, matrix_d;
   logic signed [7:0]                size_q, size_d;
   logic [2:0]                       n_q, n_d;
   logic [4:0]                       count_q, count_d;
   logic [2:0]                       row_q, row_d;
   logic [2:0]                       col_q, col_d;
   logic                             error_q, error_d;
   logic                             size_ok;
   logic [4:0]                       wr_idx;

   assign size_ok = (size > 8'sd0) && (size <= 8'sd5);

`ifdef MPU_LOADER_TRANSPOSE_EN
   assign wr_idx = 5'(row_q) + 5'(DIM) * 5'(col_q);
`else
   assign wr_idx = 5'(col_q) + 5'(DIM) * 5'(row_q);
`endif

   always_comb begin
      state_d  = state_q;
      matrix_d = matrix_q;
      size_d   = size_q;
      n_d      = n_q;
      count_d  = count_q;
      row_d    = row_q;
      col_d    = col_q;
      error_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (size_ok) begin
                  matrix_d = '0;
                  size_d   = size;
                  n_d      = size[2:0];
                  count_d  = '0;
                  row_d    = '0;
                  col_d    = '0;
                  state_d  = S_LOAD;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               for (int k = 0; k < NEL; k++) begin
                  if (5'(k) == wr_idx) matrix_d[WIDTH*k +: WIDTH] = in_data;
               end
               count_d = count_q + 5'd1;
               // Last element of the N x N region ends the load.
               if (col_q == n_q - 3'd1) begin
                  col_d = '0;
                  if (row_q == n_q - 3'd1) state_d = S_DONE;
                  else                     row_d   = row_q + 3'd1;
               end else begin
                  col_d = col_q + 3'd1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         matrix_q <= '0;
         size_q   <= '0;
         n_q      <= '0;
         count_q  <= '0;
         row_q    <= '0;
         col_q    <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         matrix_q <= matrix_d;
         size_q   <= size_d;
         n_q      <= n_d;
         count_q  <= count_d;
         row_q    <= row_d;
         col_q    <= col_d;
         error_q  <= error_d;
      end
   end

   assign in_ready = (state_q == S_LOAD);
   assign busy     = (state_q == S_LOAD);
   assign done     = (state_q == S_DONE);
   assign error    = error_q;
   assign matrix   = matrix_q;
   assign size_out = size_q;
   assign count    = count_q;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Randomized bench for mpu_matrix_loader against a placement model of the N x N stream.
module tb_mpu_matrix_loader;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                start = 1'b0;
   logic signed [7:0]   size = '0;
   logic signed [7:0]   in_data = '0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic signed [0:199] matrix;
   logic signed [7:0]   size_out;
   logic [4:0]          count;
   logic                busy;
   logic                done;
   logic                error;

   int checks = 0;
   int failures = 0;
   int vals[25];
   int expm[25];

   mpu_matrix_loader dut (
      .clock(clock), .reset(reset), .start(start), .size(size),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .matrix(matrix), .size_out(size_out), .count(count),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clock = ~clock;

   // Expected bus: stream element r*n+c goes to (r,c), or (c,r) when transposing.
   function automatic void build_exp(input int n);
      for (int k = 0; k < 25; k++) expm[k] = 0;
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
`ifdef MPU_LOADER_TRANSPOSE_EN
            expm[r + 5*c] = vals[r*n + c];
`else
            expm[c + 5*r] = vals[r*n + c];
`endif
   endfunction

   function automatic int matrix_diffs();
      int d = 0;
      for (int k = 0; k < 25; k++) begin
         logic [7:0] b;
         b = matrix[8*k +: 8];
         if (b !== 8'(expm[k])) d++;
      end
      return d;
   endfunction

   task automatic run_load(input int n, input int stall_after, input int stall_len, input bit poke,
                           output int done_edge, output int done_pulses, output int ready_bad);
      int i = 0, e = 0, st = 0, extra = 0;
      bit poked = 0;
      done_edge = -1; done_pulses = 0; ready_bad = 0;
      @(negedge clock); start = 1'b1; size = 8'(n);
      @(negedge clock); start = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (done === 1'b1) begin
            done_pulses++;
            if (done_edge < 0) done_edge = e;
         end
         if (in_ready !== (i < n*n)) ready_bad++;
         start = 1'b0;
         if (poke && !poked && i == 2) begin start = 1'b1; size = 8'sd1; poked = 1; end
         if (i < n*n && i == stall_after && st < stall_len) begin
            in_valid = 1'b0; st++;
         end else if (i < n*n) begin
            in_valid = 1'b1; in_data = 8'(vals[i]);
         end else if (extra == 0) begin
            in_valid = 1'b1; in_data = 8'h5A; extra = 1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clock); e++;
         if (in_valid && i < n*n) i++;
         if (e > n*n + stall_len + 3) break;
      end
      in_valid = 1'b0; start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
          count !== 5'd0 || size_out !== 8'sd0 || matrix !== '0) begin
         failures++;
         $display("FAIL reset_state: ready=%b busy=%b done=%b error=%b count=%0d size_out=%0d matrix_nonzero=%b, required all zero",
                  in_ready, busy, done, error, count, size_out, |matrix);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int de, dp, rb;
      vals[0] = 3; vals[1] = -1; vals[2] = 4; vals[3] = 2;
      build_exp(2);
      run_load(2, -1, 0, 0, de, dp, rb);
      checks++; if (dp !== 1) begin failures++; $display("FAIL basic_done_pulses: got %0d required 1", dp); end
      checks++; if (de !== 4) begin failures++; $display("FAIL basic_done_edge: got %0d required 4", de); end
      checks++; if (rb !== 0) begin failures++; $display("FAIL basic_in_ready: %0d bad cycles required 0", rb); end
      checks++; if (matrix_diffs() !== 0) begin failures++; $display("FAIL basic_matrix: %0d bytes differ required 0", matrix_diffs()); end
      checks++; if (size_out !== 8'sd2 || count !== 5'd4 || busy !== 1'b0) begin
         failures++; $display("FAIL basic_status: size_out=%0d count=%0d busy=%b required 2 4 0", size_out, count, busy);
      end
   endtask

   task automatic test_stall();
      int de, dp, rb;
      for (int k = 0; k < 25; k++) vals[k] = k + 1;
      build_exp(5);
      run_load(5, 7, 3, 0, de, dp, rb);
      checks++; if (dp !== 1 || de !== 28) begin failures++; $display("FAIL stall_done: pulses=%0d edge=%0d required 1 28", dp, de); end
      checks++; if (rb !== 0) begin failures++; $display("FAIL stall_in_ready: %0d bad cycles required 0", rb); end
      checks++; if (matrix_diffs() !== 0) begin failures++; $display("FAIL stall_matrix: %0d bytes differ required 0", matrix_diffs()); end
      checks++; if (count !== 5'd25) begin failures++; $display("FAIL stall_count: got %0d required 25", count); end
   endtask

   task automatic test_error();
      int bad[3];
      logic signed [7:0] prev_size;
      bad[0] = 0; bad[1] = 6; bad[2] = -3;
      prev_size = 8'sd5;
      for (int t = 0; t < 3; t++) begin
         @(negedge clock); start = 1'b1; size = 8'(bad[t]);
         @(negedge clock); start = 1'b0;
         checks++;
         if (error !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL error_pulse size=%0d: error=%b ready=%b busy=%b required 1 0 0", bad[t], error, in_ready, busy);
         end
         @(negedge clock);
         checks++;
         if (error !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL error_one_cycle size=%0d: error=%b ready=%b required 0 0", bad[t], error, in_ready);
         end
         checks++;
         if (matrix_diffs() !== 0 || size_out !== prev_size) begin
            failures++; $display("FAIL error_hold size=%0d: diffs=%0d size_out=%0d required 0 %0d", bad[t], matrix_diffs(), size_out, prev_size);
         end
      end
   endtask

   task automatic test_start_ignored();
      int de, dp, rb;
      for (int k = 0; k < 9; k++) vals[k] = int'($urandom_range(0, 255)) - 128;
      build_exp(3);
      run_load(3, -1, 0, 1, de, dp, rb);
      checks++; if (dp !== 1 || de !== 9) begin failures++; $display("FAIL ignore_done: pulses=%0d edge=%0d required 1 9", dp, de); end
      checks++; if (matrix_diffs() !== 0 || size_out !== 8'sd3 || rb !== 0) begin
         failures++; $display("FAIL ignore_matrix: diffs=%0d size_out=%0d ready_bad=%0d required 0 3 0", matrix_diffs(), size_out, rb);
      end
   endtask

   task automatic test_reset_mid_load();
      int de, dp, rb, seen;
      for (int k = 0; k < 9; k++) vals[k] = int'($urandom_range(1, 127));
      @(negedge clock); start = 1'b1; size = 8'sd3;
      @(negedge clock); start = 1'b0;
      for (int j = 0; j < 5; j++) begin
         in_valid = 1'b1; in_data = 8'(vals[j]);
         @(negedge clock);
      end
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      build_exp(0);
      checks++;
      if (matrix_diffs() !== 0 || count !== 5'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         failures++; $display("FAIL reset_abort: diffs=%0d count=%0d busy=%b ready=%b required 0 0 0 0", matrix_diffs(), count, busy, in_ready);
      end
      @(negedge clock); reset = 1'b0;
      seen = 0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clock);
         if (done === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL reset_no_done: got %0d pulses required 0", seen); end
      vals[0] = 7;
      build_exp(1);
      run_load(1, -1, 0, 0, de, dp, rb);
      checks++; if (matrix_diffs() !== 0 || dp !== 1 || de !== 1) begin
         failures++; $display("FAIL reset_reload: diffs=%0d pulses=%0d edge=%0d required 0 1 1", matrix_diffs(), dp, de);
      end
   endtask

   task automatic test_random();
      int de, dp, rb, n, sa, sl;
      for (int it = 0; it < 10; it++) begin
         n = int'($urandom_range(1, 5));
         for (int k = 0; k < 25; k++) vals[k] = int'($urandom_range(0, 255)) - 128;
         sa = int'($urandom_range(0, 24));
         sl = int'($urandom_range(0, 4));
         if (sa >= n*n) sl = 0;
         build_exp(n);
         run_load(n, sa, sl, 0, de, dp, rb);
         checks++;
         if (dp !== 1 || de !== n*n + sl || rb !== 0) begin
            failures++; $display("FAIL random_timing it=%0d n=%0d: pulses=%0d edge=%0d ready_bad=%0d required 1 %0d 0", it, n, dp, de, rb, n*n + sl);
         end
         checks++;
         if (matrix_diffs() !== 0 || count !== 5'(n*n) || size_out !== 8'(n)) begin
            failures++; $display("FAIL random_result it=%0d n=%0d: diffs=%0d count=%0d size_out=%0d required 0 %0d %0d", it, n, matrix_diffs(), count, size_out, n*n, n);
         end
      end
   endtask

`ifdef MPU_LOADER_TRANSPOSE_EN
   task automatic test_transpose();
      int de, dp, rb;
      logic [7:0] b0, b1, b5, b6;
      vals[0] = 1; vals[1] = 2; vals[2] = 3; vals[3] = 4;
      run_load(2, -1, 0, 0, de, dp, rb);
      b0 = matrix[0 +: 8]; b1 = matrix[8 +: 8]; b5 = matrix[40 +: 8]; b6 = matrix[48 +: 8];
      checks++;
      if (b0 !== 8'd1 || b1 !== 8'd3 || b5 !== 8'd2 || b6 !== 8'd4 || dp !== 1) begin
         failures++; $display("FAIL transpose: bytes=%0d %0d %0d %0d pulses=%0d required 1 3 2 4 1", b0, b1, b5, b6, dp);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_error();
      test_start_ignored();
      test_reset_mid_load();
      test_random();
`ifdef MPU_LOADER_TRANSPOSE_EN
      test_transpose();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
